// File: rtl/ysyx_22051013_axi_rd_arbiter_pkg.sv
// Shared constants for the two-master AXI read arbiter: response codes,
// master indices and the arbiter FSM encoding.
package ysyx_22051013_axi_rd_arbiter_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic IFU = 1'b0;
    localparam logic LSU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_e;

endpackage

// File: rtl/ysyx_22051013_rr_arb2.sv
// Two-request round-robin grant: a lone requester wins outright, and on a
// tie the master that was not served last wins.
module ysyx_22051013_rr_arb2
    import ysyx_22051013_axi_rd_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (req == 2'b11) ? ~last_grant : req[LSU];
    end

endmodule

// File: rtl/ysyx_22051013_axi_rd_arbiter.sv
// Arbitrates the IFU and LSU AXI read masters onto one memory read port,
// one outstanding transaction at a time, with round-robin priority on ties.
module ysyx_22051013_axi_rd_arbiter
    import ysyx_22051013_axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ifu_ar_addr,
    input  logic              ifu_ar_valid,
    output logic              ifu_ar_ready,
    output logic [DATA_W-1:0] ifu_r_data,
    output logic [1:0]        ifu_r_resp,
    output logic              ifu_r_valid,
    input  logic              ifu_r_ready,

    input  logic [ADDR_W-1:0] lsu_ar_addr,
    input  logic              lsu_ar_valid,
    output logic              lsu_ar_ready,
    output logic [DATA_W-1:0] lsu_r_data,
    output logic [1:0]        lsu_r_resp,
    output logic              lsu_r_valid,
    input  logic              lsu_r_ready,

    output logic [ADDR_W-1:0] mem_ar_addr,
    output logic              mem_ar_valid,
    input  logic              mem_ar_ready,
    input  logic [DATA_W-1:0] mem_r_data,
    input  logic [1:0]        mem_r_resp,
    input  logic              mem_r_valid,
    output logic              mem_r_ready
);

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;

    logic   gnt_valid, gnt_idx;

    // Signals for whichever master currently holds the grant.
    logic              ar_ready_g;
    logic              r_valid_g;
    logic              r_ready_g;
    logic [DATA_W-1:0] r_data_g;
    logic [1:0]        r_resp_g;

    ysyx_22051013_rr_arb2 u_rr_arb2 (
        .req        ({lsu_ar_valid, ifu_ar_valid}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_ar_valid = 1'b0;
        mem_ar_addr  = '0;
        ar_ready_g   = 1'b0;
        r_valid_g    = 1'b0;
        r_ready_g    = 1'b0;
        r_data_g     = '0;
        r_resp_g     = RESP_OKAY;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    grant_d = gnt_idx;
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                mem_ar_valid = 1'b1;
                mem_ar_addr  = (grant_q == LSU) ? lsu_ar_addr : ifu_ar_addr;
                ar_ready_g   = mem_ar_ready;
                if (mem_ar_ready) state_d = ST_R;
            end
            ST_R: begin
                r_ready_g = (grant_q == LSU) ? lsu_r_ready : ifu_r_ready;
                r_valid_g = mem_r_valid;
                r_data_g  = mem_r_data;
                r_resp_g  = mem_r_resp;
                if (mem_r_valid && r_ready_g) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_r_ready  = r_ready_g;

    assign ifu_ar_ready = (grant_q == IFU) && ar_ready_g;
    assign ifu_r_valid  = (grant_q == IFU) && r_valid_g;
    assign ifu_r_data   = (grant_q == IFU) ? r_data_g : '0;
    assign ifu_r_resp   = (grant_q == IFU) ? r_resp_g : RESP_OKAY;

    assign lsu_ar_ready = (grant_q == LSU) && ar_ready_g;
    assign lsu_r_valid  = (grant_q == LSU) && r_valid_g;
    assign lsu_r_data   = (grant_q == LSU) ? r_data_g : '0;
    assign lsu_r_resp   = (grant_q == LSU) ? r_resp_g : RESP_OKAY;

    // Reset abandons any transaction in flight; last_grant = IFU lets the LSU win the first tie.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= IFU;
            last_grant_q <= IFU;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22051013_axi_rd_arbiter.sv
// Bench for the two-master AXI read arbiter: a hand-built cycle table for the
// corner cases, then randomized traffic against a transaction-level model.
module tb_ysyx_22051013_axi_rd_arbiter;

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic        lv;
        logic        mar;
        logic        mrv;
        logic        irr;
        logic        lrr;
        logic [1:0]  resp;
        logic [63:0] data;
        logic [63:0] iaddr;
        logic [63:0] laddr;
    } in_t;

    typedef struct packed {
        logic        mav;
        logic [63:0] maddr;
        logic        iar;
        logic        lar;
        logic        irv;
        logic        lrv;
        logic        mrr;
        logic [63:0] idata;
        logic [1:0]  iresp;
        logic [63:0] ldata;
        logic [1:0]  lresp;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam logic [63:0] A0  = 64'h8000_0000;
    localparam logic [63:0] A4  = 64'h8000_0004;
    localparam logic [63:0] A1K = 64'h8000_1000;
    localparam logic [63:0] A2K = 64'h8000_2000;
    localparam logic [63:0] A3K = 64'h8000_3000;
    localparam logic [63:0] D13 = 64'h0000_0013_0000_0013;
    localparam logic [63:0] DED = 64'h0000_0000_0000_DEAD;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ifu_ar_addr, lsu_ar_addr, mem_ar_addr;
    logic        ifu_ar_valid, ifu_ar_ready, ifu_r_valid, ifu_r_ready;
    logic        lsu_ar_valid, lsu_ar_ready, lsu_r_valid, lsu_r_ready;
    logic [63:0] ifu_r_data, lsu_r_data, mem_r_data;
    logic [1:0]  ifu_r_resp, lsu_r_resp, mem_r_resp;
    logic        mem_ar_valid, mem_ar_ready, mem_r_valid, mem_r_ready;

    int n_vec = 0;
    int n_bad = 0;

    vec_t tbl[$];

    // Reference model: who owns the port (-1 = nobody), whether its address
    // has been accepted yet, and who was served last.
    int owner;
    bit sent;
    int prev;

    always #5 clk = ~clk;

    ysyx_22051013_axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .ifu_ar_addr  (ifu_ar_addr),
        .ifu_ar_valid (ifu_ar_valid),
        .ifu_ar_ready (ifu_ar_ready),
        .ifu_r_data   (ifu_r_data),
        .ifu_r_resp   (ifu_r_resp),
        .ifu_r_valid  (ifu_r_valid),
        .ifu_r_ready  (ifu_r_ready),
        .lsu_ar_addr  (lsu_ar_addr),
        .lsu_ar_valid (lsu_ar_valid),
        .lsu_ar_ready (lsu_ar_ready),
        .lsu_r_data   (lsu_r_data),
        .lsu_r_resp   (lsu_r_resp),
        .lsu_r_valid  (lsu_r_valid),
        .lsu_r_ready  (lsu_r_ready),
        .mem_ar_addr  (mem_ar_addr),
        .mem_ar_valid (mem_ar_valid),
        .mem_ar_ready (mem_ar_ready),
        .mem_r_data   (mem_r_data),
        .mem_r_resp   (mem_r_resp),
        .mem_r_valid  (mem_r_valid),
        .mem_r_ready  (mem_r_ready)
    );

    function automatic in_t mk_in(input logic r, input logic iv, input logic lv,
                                  input logic [63:0] iaddr, input logic [63:0] laddr,
                                  input logic mar, input logic mrv, input logic [63:0] data,
                                  input logic [1:0] resp, input logic irr, input logic lrr);
        in_t v;
        v.rst = r;    v.iv = iv;   v.lv = lv;     v.mar = mar;   v.mrv = mrv;
        v.irr = irr;  v.lrr = lrr; v.resp = resp; v.data = data;
        v.iaddr = iaddr; v.laddr = laddr;
        return v;
    endfunction

    function automatic out_t mk_out(input logic mav, input logic [63:0] maddr,
                                    input logic iar, input logic lar, input logic irv,
                                    input logic lrv, input logic mrr,
                                    input logic [63:0] idata, input logic [1:0] iresp,
                                    input logic [63:0] ldata, input logic [1:0] lresp);
        out_t o;
        o.mav = mav;  o.maddr = maddr; o.iar = iar; o.lar = lar;
        o.irv = irv;  o.lrv = lrv;     o.mrr = mrr;
        o.idata = idata; o.iresp = iresp; o.ldata = ldata; o.lresp = lresp;
        return o;
    endfunction

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t v);
        rst          = v.rst;
        ifu_ar_valid = v.iv;
        lsu_ar_valid = v.lv;
        ifu_ar_addr  = v.iaddr;
        lsu_ar_addr  = v.laddr;
        mem_ar_ready = v.mar;
        mem_r_valid  = v.mrv;
        mem_r_data   = v.data;
        mem_r_resp   = v.resp;
        ifu_r_ready  = v.irr;
        lsu_r_ready  = v.lrr;
    endtask

    function automatic out_t sample();
        return mk_out(mem_ar_valid, mem_ar_addr, ifu_ar_ready, lsu_ar_ready,
                      ifu_r_valid, lsu_r_valid, mem_r_ready,
                      ifu_r_data, ifu_r_resp, lsu_r_data, lsu_r_resp);
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic run_cycle(input in_t v, input out_t exp, input string name);
        drive(v);
        #3;
        check(name, sample(), exp);
        @(posedge clk);
        #1;
    endtask

    function automatic out_t model_out(input in_t v);
        out_t o = '0;
        if (owner >= 0) begin
            if (!sent) begin
                o.mav   = 1'b1;
                o.maddr = (owner == 1) ? v.laddr : v.iaddr;
                if (owner == 0) o.iar = v.mar;
                else            o.lar = v.mar;
            end else begin
                o.mrr = (owner == 0) ? v.irr : v.lrr;
                if (owner == 0) begin
                    o.irv = v.mrv; o.idata = v.data; o.iresp = v.resp;
                end else begin
                    o.lrv = v.mrv; o.ldata = v.data; o.lresp = v.resp;
                end
            end
        end
        return o;
    endfunction

    task automatic model_step(input in_t v);
        if (!v.rst) begin
            owner = -1; sent = 1'b0; prev = 0;
        end else if (owner < 0) begin
            if (v.iv && v.lv) owner = 1 - prev;
            else if (v.iv)    owner = 0;
            else if (v.lv)    owner = 1;
        end else if (!sent) begin
            if (v.mar) sent = 1'b1;
        end else if (v.mrv && ((owner == 0) ? v.irr : v.lrr)) begin
            prev  = owner;
            owner = -1;
            sent  = 1'b0;
        end
    endtask

    initial begin
        out_t z;
        in_t  hold, v;
        out_t exp;
        logic w;
        z = '0;

        // Unchecked reset cycle: outputs before the first edge are unknown.
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        @(posedge clk);
        #1;

        // Reset state, held with requests and memory activity present.
        add(mk_in(0, 1, 1, A0, A1K, 1, 1, D13, 0, 1, 1), z);
        // IFU alone: address in cycle 1, data in cycle 2, LSU side silent.
        add(mk_in(1, 1, 0, A0, 0, 1, 0, 0, 0, 1, 1), z);
        add(mk_in(1, 1, 0, A0, 0, 1, 0, 0, 0, 1, 1), mk_out(1, A0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add(mk_in(1, 0, 0, 0, 0, 1, 1, D13, 0, 1, 1), mk_out(0, 0, 0, 0, 1, 0, 1, D13, 0, 0, 0));
        add(mk_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1), z);
        // Tie straight after reset: LSU first, then IFU, six cycles total.
        add(mk_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1), z);
        add(mk_in(1, 1, 1, A4, A1K, 1, 0, 0, 0, 1, 1), z);
        add(mk_in(1, 1, 1, A4, A1K, 1, 0, 0, 0, 1, 1), mk_out(1, A1K, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add(mk_in(1, 1, 0, A4, 0, 1, 1, 64'h11, 0, 1, 1), mk_out(0, 0, 0, 0, 0, 1, 1, 0, 0, 64'h11, 0));
        add(mk_in(1, 1, 0, A4, 0, 1, 0, 0, 0, 1, 1), z);
        add(mk_in(1, 1, 0, A4, 0, 1, 0, 0, 0, 1, 1), mk_out(1, A4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add(mk_in(1, 0, 0, 0, 0, 1, 1, 64'h22, 0, 1, 1), mk_out(0, 0, 0, 0, 1, 0, 1, 64'h22, 0, 0, 0));
        // AR stalled three cycles, then SLVERR with data 0xDEAD and a master back-pressure cycle.
        add(mk_in(1, 0, 1, 0, A2K, 0, 0, 0, 0, 1, 1), z);
        for (int k = 0; k < 3; k++)
            add(mk_in(1, 0, 1, 0, A2K, 0, 0, 0, 0, 1, 1), mk_out(1, A2K, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(mk_in(1, 0, 1, 0, A2K, 1, 0, 0, 0, 1, 1), mk_out(1, A2K, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add(mk_in(1, 0, 0, 0, 0, 1, 0, DED, 2, 1, 1), mk_out(0, 0, 0, 0, 0, 0, 1, 0, 0, DED, 2));
        add(mk_in(1, 0, 0, 0, 0, 1, 1, DED, 2, 1, 0), mk_out(0, 0, 0, 0, 0, 1, 0, 0, 0, DED, 2));
        add(mk_in(1, 0, 0, 0, 0, 1, 1, DED, 2, 1, 1), mk_out(0, 0, 0, 0, 0, 1, 1, 0, 0, DED, 2));
        add(mk_in(1, 0, 0, 0, 0, 1, 1, DED, 2, 1, 1), z);
        // Reset while in R with a response pending, then a fresh LSU read.
        add(mk_in(1, 1, 0, A0, 0, 1, 0, 0, 0, 1, 1), z);
        add(mk_in(1, 1, 0, A0, 0, 1, 0, 0, 0, 1, 1), mk_out(1, A0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add(mk_in(0, 0, 0, 0, 0, 1, 1, 64'h33, 0, 1, 1), mk_out(0, 0, 0, 0, 1, 0, 1, 64'h33, 0, 0, 0));
        add(mk_in(1, 0, 0, 0, 0, 1, 1, 64'h33, 0, 1, 1), z);
        add(mk_in(1, 0, 1, 0, A3K, 1, 0, 0, 0, 1, 1), z);
        add(mk_in(1, 0, 1, 0, A3K, 1, 0, 0, 0, 1, 1), mk_out(1, A3K, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add(mk_in(1, 0, 0, 0, 0, 1, 1, 64'h44, 0, 1, 1), mk_out(0, 0, 0, 0, 0, 1, 1, 0, 0, 64'h44, 0));
        add(mk_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1), z);

        for (int k = 0; k < tbl.size(); k++)
            run_cycle(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));

        // Both masters hold requests: grants alternate LSU, IFU, LSU, IFU.
        run_cycle(mk_in(0, 1, 1, A4, A1K, 1, 1, 64'h55, 0, 1, 1), z, "hold_rst");
        hold = mk_in(1, 1, 1, A4, A1K, 1, 1, 64'h55, 0, 1, 1);
        for (int t = 0; t < 4; t++) begin
            w = (t % 2 == 0);
            run_cycle(hold, z, $sformatf("hold%0d_idle", t));
            run_cycle(hold, mk_out(1, w ? A1K : A4, !w, w, 0, 0, 0, 0, 0, 0, 0),
                      $sformatf("hold%0d_ar", t));
            run_cycle(hold, mk_out(0, 0, 0, 0, !w, w, 1, w ? 64'h0 : 64'h55, 0,
                                   w ? 64'h55 : 64'h0, 0), $sformatf("hold%0d_r", t));
        end

        // Randomized traffic against the model, starting from a known reset.
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        @(posedge clk);
        #1;
        owner = -1; sent = 1'b0; prev = 0;
        for (int c = 0; c < 3000; c++) begin
            v = mk_in($urandom_range(0, 49) != 0,
                      $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                      {$urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            exp = model_out(v);
            drive(v);
            #3;
            check($sformatf("rand%0d", c), sample(), exp);
            model_step(v);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
